serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_if.sv | 26 ++
 rtl/serial_adder_ctrl.sv | 122 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Handshake and data bundle for the bit-serial adder controller.
//   start, a, b, cin : request and operands, driven by the master
//   busy, done       : progress status and one-cycle completion pulse, driven by the slave
//   sum, cout        : registered result, driven by the slave
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands through a single
// 1-bit full adder cell, one bit per clock, LSB first.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of serial_adder_if (start/a/b/cin in, busy/done/sum/cout out)
// An accepted request runs for WIDTH edges; the final edge publishes
// {cout, sum} = a + b + cin and pulses done for one cycle.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic fa_s, fa_c;
  logic last_bit;
  logic accept;

  // The single full adder cell fed from the low bits of the shift registers.
  assign fa_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign fa_c = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

  assign last_bit = (cnt_q == CntW'(WIDTH - 1));
  assign accept   = (state_q == StIdle) && bus.start;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = StIdle;
    unique case (state_q)
      StIdle:  state_d = bus.start ? StRun : StIdle;
      StRun:   state_d = last_bit ? StIdle : StRun;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: load on accept, shift one bit per RUN edge.
  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    psum_d  = psum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    if (accept) begin
      a_sh_d  = bus.a;
      b_sh_d  = bus.b;
      carry_d = bus.cin;
      cnt_d   = '0;
      psum_d  = '0;
    end else if (state_q == StRun) begin
      a_sh_d  = a_sh_q >> 1;
      b_sh_d  = b_sh_q >> 1;
      // Sum bits enter at the top so bit 0 lands in place after WIDTH shifts.
      psum_d  = {fa_s, psum_q[WIDTH-1:1]};
      carry_d = fa_c;
      cnt_d   = cnt_q + CntW'(1);
      if (last_bit) begin
        sum_d  = psum_d;
        cout_d = fa_c;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      psum_q  <= psum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    bus.busy = (state_q == StRun);
    bus.done = done_q;
    bus.sum  = sum_q;
    bus.cout = cout_q;
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

  localparam int W8 = 8;
  localparam int W2 = 2;

  logic clk = 1'b0;
  logic rst_n8 = 1'b1;
  logic rst_n2 = 1'b1;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(W8)) if8 ();
  serial_adder_if #(.WIDTH(W2)) if2 ();

  serial_adder_ctrl #(.WIDTH(W8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n8),
    .bus   (if8.slave)
  );

  serial_adder_ctrl #(.WIDTH(W2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n2),
    .bus   (if2.slave)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int timeouts = 0;
  logic chk_en = 1'b0;
  logic rst_chk = 1'b0;
  logic fin = 1'b0;
  logic fin_seen = 1'b0;
  int busy_len8 = 0;

  // Hand-computed expectations for the current WIDTH=8 operation.
  logic       lit8_v = 1'b0;
  logic [7:0] lit8_sum = '0;
  logic       lit8_cout = 1'b0;

  // Behavioural model: a request accepted while idle yields a+b+cin exactly
  // WIDTH edges later; requests during an operation are dropped.
  logic       m8_busy, m8_done, m8_cout;
  logic [7:0] m8_sum;
  logic [8:0] m8_res;
  int         m8_left;

  always @(posedge clk or negedge rst_n8) begin
    if (!rst_n8) begin
      m8_busy <= 1'b0; m8_done <= 1'b0; m8_cout <= 1'b0;
      m8_sum <= '0; m8_res <= '0; m8_left <= 0;
    end else begin
      m8_done <= 1'b0;
      if (!m8_busy) begin
        if (if8.start) begin
          m8_busy <= 1'b1;
          m8_left <= W8;
          m8_res  <= 9'(if8.a) + 9'(if8.b) + 9'(if8.cin);
        end
      end else begin
        m8_left <= m8_left - 1;
        if (m8_left == 1) begin
          m8_busy <= 1'b0;
          m8_done <= 1'b1;
          {m8_cout, m8_sum} <= m8_res;
        end
      end
    end
  end

  logic       m2_busy, m2_done, m2_cout;
  logic [1:0] m2_sum;
  logic [2:0] m2_res;
  int         m2_left;

  always @(posedge clk or negedge rst_n2) begin
    if (!rst_n2) begin
      m2_busy <= 1'b0; m2_done <= 1'b0; m2_cout <= 1'b0;
      m2_sum <= '0; m2_res <= '0; m2_left <= 0;
    end else begin
      m2_done <= 1'b0;
      if (!m2_busy) begin
        if (if2.start) begin
          m2_busy <= 1'b1;
          m2_left <= W2;
          m2_res  <= 3'(if2.a) + 3'(if2.b) + 3'(if2.cin);
        end
      end else begin
        m2_left <= m2_left - 1;
        if (m2_left == 1) begin
          m2_busy <= 1'b0;
          m2_done <= 1'b1;
          {m2_cout, m2_sum} <= m2_res;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Single compare process, sampling on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("busy8", 32'(if8.busy), 32'(m8_busy));
        chk("done8", 32'(if8.done), 32'(m8_done));
        chk("sum8",  32'(if8.sum),  32'(m8_sum));
        chk("cout8", 32'(if8.cout), 32'(m8_cout));
        chk("busy2", 32'(if2.busy), 32'(m2_busy));
        chk("done2", 32'(if2.done), 32'(m2_done));
        chk("sum2",  32'(if2.sum),  32'(m2_sum));
        chk("cout2", 32'(if2.cout), 32'(m2_cout));
        if (rst_chk) begin
          chk("rst_busy8", 32'(if8.busy), 32'd0);
          chk("rst_done8", 32'(if8.done), 32'd0);
          chk("rst_sum8",  32'(if8.sum),  32'd0);
          chk("rst_cout8", 32'(if8.cout), 32'd0);
        end
        if (if8.done && lit8_v) begin
          chk("lit_sum8",  32'(if8.sum),  32'(lit8_sum));
          chk("lit_cout8", 32'(if8.cout), 32'(lit8_cout));
          chk("busy_len8", 32'(busy_len8), 32'(W8));
        end
        if (!rst_n8 || !if8.busy) busy_len8 = 0;
        else busy_len8++;
        if (fin && !fin_seen) begin
          fin_seen = 1'b1;
          chk("timeouts", 32'(timeouts), 32'd0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one WIDTH=8 operation and wait (bounded) for its done pulse.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input logic [7:0] ls, input logic lc, input logic hold);
    if8.a = a; if8.b = b; if8.cin = cin; if8.start = 1'b1;
    lit8_sum = ls; lit8_cout = lc; lit8_v = 1'b1;
    tick();
    if (!hold) if8.start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (if8.done) break;
    end
    if (!if8.done) timeouts++;
    @(negedge clk);
    #1;
  endtask

  task automatic run2(input logic [1:0] a, input logic [1:0] b, input logic cin);
    if2.a = a; if2.b = b; if2.cin = cin; if2.start = 1'b1;
    tick();
    if2.start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (if2.done) break;
    end
    if (!if2.done) timeouts++;
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
    if2.start = 1'b0; if2.a = '0; if2.b = '0; if2.cin = 1'b0;
    #1;
    rst_n8 = 1'b0;
    rst_n2 = 1'b0;
    rst_chk = 1'b1;
    #1;
    chk_en = 1'b1;
    tick();
    tick();
    rst_n8 = 1'b1;
    rst_n2 = 1'b1;
    rst_chk = 1'b0;

    run8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    run8(8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0, 1'b0);

    // A second request in the middle of RUN must be dropped.
    if8.a = 8'h12; if8.b = 8'h34; if8.cin = 1'b0; if8.start = 1'b1;
    lit8_sum = 8'h46; lit8_cout = 1'b0; lit8_v = 1'b1;
    tick();
    if8.start = 1'b0;
    tick();
    tick();
    if8.a = 8'hFF; if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (if8.done) break;
    end
    if (!if8.done) timeouts++;
    @(negedge clk);
    #1;

    // Reset in the middle of RUN abandons the operation.
    lit8_v = 1'b0;
    if8.a = 8'h80; if8.b = 8'h80; if8.cin = 1'b0; if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    repeat (4) tick();
    rst_n8 = 1'b0;
    rst_chk = 1'b1;
    tick();
    tick();
    rst_n8 = 1'b1;
    rst_chk = 1'b0;
    run8(8'h0F, 8'hF1, 1'b1, 8'h01, 1'b1, 1'b0);

    // start held high: each done cycle is idle, so its edge takes the next pair.
    run8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b1);
    run8(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b1);
    run8(8'h7F, 8'h7F, 1'b0, 8'hFE, 1'b0, 1'b1);
    if8.start = 1'b0;
    lit8_v = 1'b0;
    repeat (3) tick();

    for (int v = 0; v < 32; v++) begin
      logic [4:0] vv;
      vv = 5'(v);
      run2(vv[4:3], vv[2:1], vv[0]);
    end

    fin = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
